axi_stream_downsizer: RTL

AXI_STREAM_DOWNSIZER -- requirements
Module: axi_stream_downsizer

---
 rtl/axi_stream_downsizer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axi_stream_downsizer.sv
// AXI-Stream width downsizer: splits one wide input beat into RATIO narrow lanes,
// skipping lanes with no keep bits set and dropping fully empty non-last beats.
module axi_stream_downsizer #(
  parameter int    IN_WIDTH     = 64,
  parameter int    RATIO        = 2,
  parameter int    USER_WIDTH   = 8,
  parameter string USER_ON_LAST = "false",
  localparam int   OUT_WIDTH    = IN_WIDTH / RATIO,
  localparam int   KEEP_IN      = IN_WIDTH / 8,
  localparam int   KEEP_OUT     = OUT_WIDTH / 8
) (
  input  logic                  sysClk,
  input  logic                  sysReset,
  input  logic [IN_WIDTH-1:0]   sAxiStreamTdata,
  input  logic [KEEP_IN-1:0]    sAxiStreamTkeep,
  input  logic [USER_WIDTH-1:0] sAxiStreamTuser,
  input  logic                  sAxiStreamTlast,
  input  logic                  sAxiStreamTvalid,
  output logic                  sAxiStreamTready,
  output logic [OUT_WIDTH-1:0]  mAxiStreamTdata,
  output logic [KEEP_OUT-1:0]   mAxiStreamTkeep,
  output logic [USER_WIDTH-1:0] mAxiStreamTuser,
  output logic                  mAxiStreamTlast,
  output logic                  mAxiStreamTvalid,
  input  logic                  mAxiStreamTready,
  output logic [15:0]           dropCount
);

  localparam int LANE_W = $clog2(RATIO);
  localparam bit UOL    = (USER_ON_LAST == "true");

  logic [IN_WIDTH-1:0]   data_q, data_d;
  logic [KEEP_IN-1:0]    keep_q, keep_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  last_q, last_d;
  logic                  held_q, held_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [15:0]           drop_q, drop_d;

  logic [RATIO-1:0]  cur_mask, above_mask, in_mask;
  logic [LANE_W-1:0] next_lane, first_in_lane;
  logic              is_final, in_empty, m_hs, s_hs;

  function automatic logic [RATIO-1:0] lane_mask(input logic [KEEP_IN-1:0] keep);
    logic [RATIO-1:0] m;
    m = '0;
    for (int k = 0; k < RATIO; k++) m[k] = |keep[k*KEEP_OUT +: KEEP_OUT];
    return m;
  endfunction

  // Priority encoder: lowest set lane wins; lane 0 when nothing is set.
  function automatic logic [LANE_W-1:0] lowest_lane(input logic [RATIO-1:0] m);
    logic [LANE_W-1:0] res;
    res = '0;
    for (int k = RATIO - 1; k >= 0; k--) if (m[k]) res = LANE_W'(k);
    return res;
  endfunction

  always_comb begin
    cur_mask   = lane_mask(keep_q);
    above_mask = '0;
    for (int k = 0; k < RATIO; k++) above_mask[k] = cur_mask[k] && (k > int'(lane_q));
    is_final      = ~|above_mask;
    next_lane     = lowest_lane(above_mask);
    in_mask       = lane_mask(sAxiStreamTkeep);
    in_empty      = ~|in_mask;
    first_in_lane = lowest_lane(in_mask);
  end

  assign sAxiStreamTready = !sysReset && (!held_q || (is_final && mAxiStreamTready));
  assign m_hs = held_q && mAxiStreamTready;
  assign s_hs = sAxiStreamTvalid && sAxiStreamTready;

  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    user_d = user_q;
    last_d = last_q;
    held_d = held_q;
    lane_d = lane_q;
    drop_d = drop_q;
    if (m_hs) begin
      if (is_final) held_d = 1'b0;
      else          lane_d = next_lane;
    end
    // A new beat may land in the same cycle the final lane of the old one leaves.
    if (s_hs) begin
      data_d = sAxiStreamTdata;
      keep_d = sAxiStreamTkeep;
      user_d = sAxiStreamTuser;
      last_d = sAxiStreamTlast;
      lane_d = first_in_lane;
      held_d = !(in_empty && !sAxiStreamTlast);
      if (in_empty && !sAxiStreamTlast && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      held_q <= 1'b0;
      lane_q <= '0;
      last_q <= 1'b0;
      user_q <= '0;
      drop_q <= '0;
    end else begin
      held_q <= held_d;
      lane_q <= lane_d;
      last_q <= last_d;
      user_q <= user_d;
      drop_q <= drop_d;
    end
    data_q <= data_d;
    keep_q <= keep_d;
  end

  always_comb begin
    mAxiStreamTdata = '0;
    mAxiStreamTkeep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_q == LANE_W'(k)) begin
        mAxiStreamTdata = data_q[k*OUT_WIDTH +: OUT_WIDTH];
        mAxiStreamTkeep = keep_q[k*KEEP_OUT +: KEEP_OUT];
      end
    end
  end

  assign mAxiStreamTvalid = held_q;
  assign mAxiStreamTlast  = held_q && last_q && is_final;
  assign mAxiStreamTuser  = (UOL && !mAxiStreamTlast) ? '0 : user_q;
  assign dropCount        = drop_q;

endmodule
